// File: rtl/machine_jk_pkg.sv
// machine_jk_pkg: shared width and terminal-count constants for the JK up/down counter
package machine_jk_pkg;
   localparam int STATE_W = 3;
   localparam logic [STATE_W-1:0] S_MIN = 3'b000;
   localparam logic [STATE_W-1:0] S_MAX = 3'b111;
endpackage

// File: rtl/machine_jk_jk_ff.sv
// jk_ff: rising-edge JK flip-flop with asynchronous active-high clear
module jk_ff (
   input  logic CLK,
   input  logic RESET,
   input  logic J,
   input  logic K,
   output logic Q
);
   logic q_q, q_d;
   always_comb q_d = (J & K) ? ~q_q : J ? 1'b1 : K ? 1'b0 : q_q;
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) q_q <= 1'b0;
      else q_q <= q_d;
   assign Q = q_q;
endmodule

// File: rtl/machine_jk.sv
// machine_jk: 3-bit up/down counter built from toggle-form JK flip-flops with a Mealy wrap flag
module machine_jk
   import machine_jk_pkg::*;
(
   input  logic               CLK,
   input  logic               RESET,
   input  logic               x,
   output logic               F,
   output logic [STATE_W-1:0] S
);
   logic [STATE_W-1:0] t;
   // each bit toggles when all lower bits sit at the wrap value for the current direction
   always_comb t = {x ? (S[1] & S[0]) : (~S[1] & ~S[0]), x ? S[0] : ~S[0], 1'b1};
   for (genvar i = 0; i < STATE_W; i++) begin : g_ff
      jk_ff u_ff (.CLK(CLK), .RESET(RESET), .J(t[i]), .K(t[i]), .Q(S[i]));
   end
   always_comb F = x ? (S == S_MAX) : (S == S_MIN);
endmodule

// File: tb/tb_machine_jk.sv
// tb_machine_jk: randomized and directed checks of machine_jk against a modulo-8 arithmetic model
module tb_machine_jk;
   logic CLK = 1'b0;
   logic RESET, x, F;
   logic [2:0] S;
   int n_tests = 0;
   int n_fail = 0;
   int m = 0;

   machine_jk dut (.CLK(CLK), .RESET(RESET), .x(x), .F(F), .S(S));

   always #5 CLK = ~CLK;

   function automatic logic exp_f(input int s, input logic xv);
      return (xv && s == 7) || (!xv && s == 0);
   endfunction

   task automatic tick();
      @(posedge CLK);
      m = x ? (m + 1) % 8 : (m + 7) % 8;
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      x = 1'b0;
      m = 0;
      @(negedge CLK);
      n_tests++;
      if (S !== 3'b000) begin n_fail++; $display("FAIL reset_s: got %b want 000", S); end
      n_tests++;
      if (F !== 1'b1) begin n_fail++; $display("FAIL reset_f_x0: got %b want 1", F); end
      x = 1'b1;
      #1;
      n_tests++;
      if (F !== 1'b0) begin n_fail++; $display("FAIL reset_f_x1: got %b want 0", F); end
      n_tests++;
      if (S !== 3'b000) begin n_fail++; $display("FAIL reset_s_x1: got %b want 000", S); end
      x = 1'b0;
      #1;
      RESET = 1'b0;
   endtask

   task automatic test_count_down();
      for (int i = 0; i < 9; i++) begin
         n_tests++;
         if (F !== exp_f(m, 1'b0)) begin n_fail++; $display("FAIL down_f[%0d]: got %b want %b (S=%0d)", i, F, exp_f(m, 1'b0), m); end
         tick();
         n_tests++;
         if (S !== 3'(m)) begin n_fail++; $display("FAIL down_s[%0d]: got %0d want %0d", i, S, m); end
      end
   endtask

   task automatic test_count_up();
      @(negedge CLK);
      x = 1'b1;
      #1;
      n_tests++;
      if (F !== exp_f(m, 1'b1)) begin n_fail++; $display("FAIL up_f_start: got %b want %b", F, exp_f(m, 1'b1)); end
      for (int i = 0; i < 8; i++) begin
         tick();
         n_tests++;
         if (S !== 3'(m)) begin n_fail++; $display("FAIL up_s[%0d]: got %0d want %0d", i, S, m); end
         n_tests++;
         if (F !== exp_f(m, 1'b1)) begin n_fail++; $display("FAIL up_f[%0d]: got %b want %b", i, F, exp_f(m, 1'b1)); end
      end
   endtask

   task automatic test_alternate();
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         x = (i % 2 == 0);
         #1;
         n_tests++;
         if (F !== exp_f(m, x)) begin n_fail++; $display("FAIL alt_f[%0d]: got %b want %b", i, F, exp_f(m, x)); end
         tick();
         n_tests++;
         if (S !== 3'(m)) begin n_fail++; $display("FAIL alt_s[%0d]: got %0d want %0d", i, S, m); end
      end
   endtask

   task automatic test_async_reset();
      @(posedge CLK);
      #2;
      RESET = 1'b1;
      m = 0;
      #1;
      n_tests++;
      if (S !== 3'b000) begin n_fail++; $display("FAIL async_rst_s: got %b want 000", S); end
      @(posedge CLK);
      #1;
      n_tests++;
      if (S !== 3'b000) begin n_fail++; $display("FAIL async_rst_hold: got %b want 000", S); end
      @(negedge CLK);
      RESET = 1'b0;
      x = 1'b1;
      tick();
      n_tests++;
      if (S !== 3'(m)) begin n_fail++; $display("FAIL async_rst_resume: got %0d want %0d", S, m); end
      RESET = 1'b1;
      m = 0;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      n_tests++;
      if (S !== 3'b000) begin n_fail++; $display("FAIL rst_edge_ignored: got %b want 000", S); end
      tick();
      n_tests++;
      if (S !== 3'b001) begin n_fail++; $display("FAIL rst_first_count: got %b want 001", S); end
   endtask

   task automatic test_exhaustive();
      for (int s = 0; s < 8; s++) begin
         for (int xv = 0; xv < 2; xv++) begin
            for (int k = 0; k < 8 && m != s; k++) begin
               @(negedge CLK);
               x = 1'b1;
               tick();
            end
            @(negedge CLK);
            x = xv[0];
            #1;
            n_tests++;
            if (F !== exp_f(s, x)) begin n_fail++; $display("FAIL exh_f[s=%0d x=%0d]: got %b want %b", s, xv, F, exp_f(s, x)); end
            tick();
            n_tests++;
            if (S !== 3'((s + (xv != 0 ? 1 : 7)) % 8)) begin n_fail++; $display("FAIL exh_s[s=%0d x=%0d]: got %0d want %0d", s, xv, S, (s + (xv != 0 ? 1 : 7)) % 8); end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK);
         x = 1'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            RESET = 1'b1;
            m = 0;
            #1;
            n_tests++;
            if (S !== 3'b000) begin n_fail++; $display("FAIL rnd_rst[%0d]: got %b want 000", i, S); end
            RESET = 1'b0;
         end
         #1;
         n_tests++;
         if (F !== exp_f(m, x)) begin n_fail++; $display("FAIL rnd_f[%0d]: got %b want %b (S=%0d x=%b)", i, F, exp_f(m, x), m, x); end
         tick();
         n_tests++;
         if (S !== 3'(m)) begin n_fail++; $display("FAIL rnd_s[%0d]: got %0d want %0d", i, S, m); end
      end
   endtask

   initial begin
      test_reset();
      test_count_down();
      test_count_up();
      test_alternate();
      test_async_reset();
      test_exhaustive();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
